mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_fifo.sv | 59 +++++
 rtl/mem_responder_register.sv | 25 ++
 rtl/mem_responder.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | MemMsg : memory request/response message types shared with processor code |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package MemMsg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic        mtype;
    logic [31:0] rdata;
  } mem_resp_t;

  typedef struct packed {
    logic      val;
    mem_resp_t resp;
  } dly_stage_t;

endpackage

`default_nettype wire

// File: rtl/mem_responder_fifo.sv
// +----------------------------------------------------------------------------+
// | ResponseFifo : in-order response buffer, enqueue+dequeue legal when full   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ResponseFifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_val_i,
  input  logic [WIDTH-1:0] enq_data_i,
  input  logic             deq_rdy_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic             enq_w, deq_w;

  // Extra pointer MSB distinguishes full from empty when the slot bits match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign deq_w   = deq_rdy_i & ~empty_o;
  assign enq_w   = enq_val_i & (~full_o | deq_w);
  assign head_o  = data_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (enq_w) wr_d = wr_q + 1'b1;
    if (deq_w) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_w) data_q[wr_q[PTR_W-1:0]] <= enq_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder_register.sv
// +----------------------------------------------------------------------------+
// | Register : enable-gated register with asynchronous active-high reset      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module Register #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_o <= RESET_VALUE;
    else if (en_i) q_o <= d_i;
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +----------------------------------------------------------------------------+
// | mem_responder : word-addressed memory with fixed-latency in-order replies  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_responder
  import MemMsg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 1,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_type,
  input  logic [31:0] memreq_addr,
  input  logic [31:0] memreq_wdata,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_type,
  output logic [31:0] memresp_rdata
);

  localparam int IDX_W   = $clog2(NUM_WORDS);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int STAGE_W = $bits(dly_stage_t);
  localparam int RESP_W  = $bits(mem_resp_t);

  logic [31:0]      mem_q [NUM_WORDS];
  logic [IDX_W-1:0] idx_w;
  logic             accept_w;
  logic             deq_w;
  logic             unused_addr_w;
  logic [CNT_W-1:0] count_q, count_d;
  dly_stage_t       stage_w [LATENCY];
  mem_resp_t        head_w;
  logic             fifo_full_w, fifo_empty_w;

  assign idx_w         = memreq_addr[IDX_W+1:2];
  assign unused_addr_w = ^{memreq_addr[31:IDX_W+2], memreq_addr[1:0]};
  assign accept_w      = memreq_val & memreq_rdy;
  assign deq_w         = memresp_val & memresp_rdy;
  assign memreq_rdy    = (count_q < CNT_W'(DEPTH)) & ~rst;

  always_ff @(posedge clk) begin
    if (accept_w && memreq_type == MEM_WRITE) mem_q[idx_w] <= memreq_wdata;
  end

  // Read data is taken from the array before this edge's write lands.
  assign stage_w[0].val        = accept_w;
  assign stage_w[0].resp.mtype = memreq_type;
  assign stage_w[0].resp.rdata = (memreq_type == MEM_WRITE) ? 32'h0 : mem_q[idx_w];

  for (genvar i = 1; i < LATENCY; i++) begin : g_delay
    Register #(.WIDTH(STAGE_W)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .d_i  (stage_w[i-1]),
      .q_o  (stage_w[i])
    );
  end

  ResponseFifo #(.DEPTH(DEPTH), .WIDTH(RESP_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_val_i  (stage_w[LATENCY-1].val),
    .enq_data_i (stage_w[LATENCY-1].resp),
    .deq_rdy_i  (memresp_rdy),
    .full_o     (fifo_full_w),
    .empty_o    (fifo_empty_w),
    .head_o     (head_w)
  );

  assign memresp_val   = ~fifo_empty_w;
  assign memresp_type  = memresp_val & head_w.mtype;
  assign memresp_rdata = {32{memresp_val}} & head_w.rdata;

  always_comb begin
    count_d = count_q + CNT_W'(accept_w) - CNT_W'(deq_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(stage_w[LATENCY-1].val && fifo_full_w && !deq_w));

endmodule

`default_nettype wire
